ex_mem_reg: RTL
===============

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter: WIDTH, 64, datapath width of the result and store-data fields.
REQ-002 Parameter: REG_W, 5, register-specifier width.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: stall  input  1  hold all state this cycle.
REQ-006 Port: flush  input  1  load a bubble this cycle.
REQ-007 Port: ex_valid  input  1  EX stage holds a real instruction.
REQ-008 Port: execute_output  input  WIDTH  EX result (ALU or shifter).
REQ-009 Port: store_data  input  WIDTH  register-B value for stores.
REQ-010 Port: ex_rd  input  REG_W  destination register.
REQ-011 Port: ex_regwrite, ex_memwrite, ex_memread, ex_memtoreg  input  1 each  MEM/WB controls.
REQ-012 Port: ex_setflags  input  1  instruction updates the NZVC flags.
REQ-013 Port: negative, zero, overflow, carry_out  input  1 each  EX ALU flags.
REQ-014 Port: mem_valid  output  1  MEM stage holds a real instruction.
REQ-015 Port: mem_result, mem_store_data  output  WIDTH each  registered result and store data.
REQ-016 Port: mem_rd  output  REG_W  registered destination register.
REQ-017 Port: mem_regwrite, mem_memwrite, mem_memread, mem_memtoreg  output  1 each  registered controls.
REQ-018 Port: flags  output  4  architectural {N,Z,V,C} register.
REQ-019 Port: flags_fwd  output  4  {N,Z,V,C} seen by a branch issued this cycle.
REQ-020 Port: bubble_cnt  output  16  count of bubbles loaded into MEM.

Function
REQ-021 Latency SHALL be exactly one cycle from the EX inputs to the mem_* outputs.
REQ-022 Edge rule: if flush=1, load a bubble; else if stall=1, hold every register; else load the EX inputs.
REQ-023 Flush SHALL have priority over stall when both are asserted.
REQ-024 Bubble content: mem_valid=0, all four mem_* controls=0, mem_result=0, mem_store_data=0, mem_rd=31.
REQ-025 A normal load with ex_valid=0 SHALL load a bubble identical to REQ-024.
REQ-026 A normal load with ex_valid=1 SHALL register all fields unchanged, except as given in REQ-027.
REQ-027 mem_regwrite SHALL be 0 whenever ex_rd=31 (XZR); the other fields still load.
REQ-028 Conflicting controls: if ex_memwrite=1 and ex_memread=1, mem_memread SHALL be forced to 0.
REQ-029 Flags update condition: ex_valid=1, ex_setflags=1, stall=0, flush=0; otherwise flags hold.
REQ-030 Flags update value: {negative, zero, overflow, carry_out}.
REQ-031 flags_fwd (combinational) SHALL equal the live EX flags when the REQ-029 update condition holds, else flags.
REQ-032 bubble_cnt SHALL increment by 1 on each edge that loads a bubble (REQ-024/025), and not while stall holds.
REQ-033 bubble_cnt SHALL saturate at 0xFFFF and never wrap.
REQ-034 Outputs SHALL have no combinational path from inputs, except flags_fwd.

Reset
REQ-035 reset=0 SHALL immediately, without waiting for a clock edge, force the bubble state of REQ-024, flags=4'b0000 and bubble_cnt=0.
REQ-036 Reset asserted mid-stall or mid-flush SHALL override both; after release, the first rising edge follows REQ-022.
REQ-037 flags_fwd SHALL read 4'b0000 during reset unless the REQ-031 forwarding condition holds.

Verification
REQ-038 Normal load: ex_valid=1, execute_output=0x1234, ex_rd=3, ex_regwrite=1 -> next cycle mem_result=0x1234, mem_rd=3, mem_regwrite=1, mem_valid=1.
REQ-039 XZR write: ex_rd=31, ex_regwrite=1, ex_valid=1 -> mem_regwrite=0, mem_rd=31, mem_valid=1.
REQ-040 Flags: ex_setflags=1, Z=1, C=1, stall=0 -> flags_fwd=4'b0101 in the same cycle, flags=4'b0101 next cycle; repeat with stall=1 -> flags unchanged.
REQ-041 Stall and flush together: registered mem_result=0xAA; stall=1 for 3 cycles -> outputs hold 0xAA, bubble_cnt unchanged; stall=1 and flush=1 -> bubble, bubble_cnt+1.
REQ-042 Saturation: preload with 65535 bubbles, load one more bubble -> bubble_cnt stays 0xFFFF.
REQ-043 Async reset: assert reset=0 between clock edges while mem_valid=1 -> mem_valid=0, flags=0 and bubble_cnt=0 before the next edge.

Source files
------------

// File: rtl/ex_mem_reg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_reg
// Purpose  : EX/MEM pipeline register. Captures the EX-stage result, store
//            data, destination register and MEM/WB controls on each rising
//            edge. Also holds the architectural NZVC flags register with a
//            same-cycle forward path for branches, and a saturating count of
//            bubbles loaded into MEM.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous active-low reset
//   stall          in   1      hold all state this cycle
//   flush          in   1      load a bubble this cycle (beats stall)
//   ex_valid       in   1      EX holds a real instruction
//   execute_output in   WIDTH  EX result
//   store_data     in   WIDTH  register-B value for stores
//   ex_rd          in   REG_W  destination register
//   ex_regwrite/ex_memwrite/ex_memread/ex_memtoreg  in 1 each  controls
//   ex_setflags    in   1      instruction updates NZVC
//   negative/zero/overflow/carry_out  in 1 each  live EX flags
//   mem_valid      out  1      MEM holds a real instruction
//   mem_result     out  WIDTH  registered result
//   mem_store_data out  WIDTH  registered store data
//   mem_rd         out  REG_W  registered destination register
//   mem_regwrite/mem_memwrite/mem_memread/mem_memtoreg  out 1 each
//   flags          out  4      architectural {N,Z,V,C}
//   flags_fwd      out  4      {N,Z,V,C} seen by a branch this cycle
//   bubble_cnt     out  16     saturating count of bubbles loaded
// ============================================================================
module ex_mem_reg #(
  parameter int WIDTH = 64,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [WIDTH-1:0] execute_output,
  input  logic [WIDTH-1:0] store_data,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memwrite,
  input  logic             ex_memread,
  input  logic             ex_memtoreg,
  input  logic             ex_setflags,
  input  logic             negative,
  input  logic             zero,
  input  logic             overflow,
  input  logic             carry_out,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_result,
  output logic [WIDTH-1:0] mem_store_data,
  output logic [REG_W-1:0] mem_rd,
  output logic             mem_regwrite,
  output logic             mem_memwrite,
  output logic             mem_memread,
  output logic             mem_memtoreg,
  output logic [3:0]       flags,
  output logic [3:0]       flags_fwd,
  output logic [15:0]      bubble_cnt
);

  localparam logic [REG_W-1:0] c_XZR     = REG_W'(31);
  localparam logic [15:0]      c_CNT_MAX = 16'hFFFF;

  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_store_data;
  logic [REG_W-1:0] r_rd;
  logic             r_regwrite;
  logic             r_memwrite;
  logic             r_memread;
  logic             r_memtoreg;
  logic [3:0]       r_flags;
  logic [15:0]      r_bubble_cnt;

  logic             w_load_bubble;
  logic             w_load_ex;
  logic             w_flag_upd;
  logic [3:0]       w_ex_flags;

  // Flush beats stall; an invalid EX slot on a normal edge is also a bubble.
  assign w_load_bubble = flush | (~stall & ~ex_valid);
  assign w_load_ex     = ~flush & ~stall & ex_valid;
  // Flags only move when a real, non-stalled, non-flushed instruction asks.
  assign w_flag_upd    = w_load_ex & ex_setflags;
  assign w_ex_flags    = {negative, zero, overflow, carry_out};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_rd         <= c_XZR;
      r_regwrite   <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (w_load_bubble) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_store_data <= '0;
      r_rd         <= c_XZR;
      r_regwrite   <= 1'b0;
      r_memwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memtoreg   <= 1'b0;
      if (r_bubble_cnt != c_CNT_MAX) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end else if (w_load_ex) begin
      r_valid      <= 1'b1;
      r_result     <= execute_output;
      r_store_data <= store_data;
      r_rd         <= ex_rd;
      // Writes to XZR are architecturally discarded.
      r_regwrite   <= ex_regwrite & (ex_rd != c_XZR);
      r_memwrite   <= ex_memwrite;
      // A store wins over a conflicting load request.
      r_memread    <= ex_memread & ~ex_memwrite;
      r_memtoreg   <= ex_memtoreg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_flag_upd) begin
      r_flags <= w_ex_flags;
    end
  end

  assign mem_valid      = r_valid;
  assign mem_result     = r_result;
  assign mem_store_data = r_store_data;
  assign mem_rd         = r_rd;
  assign mem_regwrite   = r_regwrite;
  assign mem_memwrite   = r_memwrite;
  assign mem_memread    = r_memread;
  assign mem_memtoreg   = r_memtoreg;
  assign flags          = r_flags;
  assign bubble_cnt     = r_bubble_cnt;
  // Same-cycle bypass so a branch sees flags being written this edge;
  // not gated by reset, so it still forwards while reset is held.
  assign flags_fwd      = w_flag_upd ? w_ex_flags : r_flags;

endmodule
`default_nettype wire
